digit_counter_2d: RTL
=====================

Name: digit_counter_2d

Overview:
Two-digit run/pause/clear counter that produces the tens and ones nibbles for the pair of binary_to_7segment decoders on the Go Board. It sits directly upstream of the segment decoders and downstream of the debounce_switch instances. It detects edges on the debounced switch levels, prescales i_clk into a count tick, and steps a decimal or hex two-digit value up or down.

Parameters:
CLKS_PER_TICK, 25000000, i_clk cycles per count step (1 s at 25 MHz); legal range is 2 or more.
DIGIT_MAX, 9, maximum value of each digit: 9 gives decimal 00-99, 15 gives hex 00-FF; legal range is 1..15.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start_stop  in  1  debounced level; each rising edge toggles run/pause
i_clear  in  1  debounced level; a rising edge returns the block to 00/IDLE
i_count_down  in  1  level; 1 = decrement, 0 = increment; sampled at each tick
o_left_digit  out  4  tens digit, to the left segment decoder
o_right_digit  out  4  ones digit, to the right segment decoder
o_running  out  1  high while the block is in RUN
o_tick  out  1  one-cycle pulse, coincident with each digit update
o_wrap  out  1  one-cycle pulse, coincident with a 99->00 or 00->99 rollover

Behaviour:
- Reset (i_rst_n low, async):
  - state=IDLE, digits=0, prescaler=0, all outputs 0.
  - Edge-detect history registers reset to 1, so a switch already held at release gives no spurious edge.
- Edge detection: rise = input & ~prev, with prev registered each cycle. Action is taken at the same edge that samples rise, so the new state is visible one cycle after the input first samples high.
- State machine (2-bit):
  - IDLE -start edge-> RUN.
  - RUN -start edge-> PAUSED.
  - PAUSED -start edge-> RUN.
  - Any state -clear edge-> IDLE.
  - Clear and start edges in the same cycle: clear wins and the start edge is discarded.
- Clear: digits=00, prescaler=0, state=IDLE. Clear in IDLE is a no-op.
- Prescaler: counts 0..CLKS_PER_TICK-1 only in RUN.
  - Holds its value in PAUSED, so a resume completes the partial period.
  - Width is $clog2(CLKS_PER_TICK).
- Tick: when prescaler==CLKS_PER_TICK-1 in RUN, the prescaler returns to 0 and the digits step.
  - o_tick is registered and goes high the cycle the new digits appear.
  - First tick comes CLKS_PER_TICK cycles after o_running rises.
- Up step: right+1.
  - If right==DIGIT_MAX: right=0, left+1.
  - If both are at DIGIT_MAX: both go to 0 and o_wrap pulses.
- Down step: right-1.
  - If right==0: right=DIGIT_MAX, left-1.
  - If both are 0: both go to DIGIT_MAX and o_wrap pulses.
- A direction change takes effect at the next tick only.
- Digits never exceed DIGIT_MAX; the 4-bit arithmetic never overflows.
- Start edge arriving on the tick cycle: the tick step completes, then the state changes to PAUSED.

Optional Feature:
DIGIT_COUNTER_LAP_EN
- Defined:
  - Adds input port i_lap (1 bit, debounced level).
  - A rising edge in RUN or PAUSED toggles a freeze flag. While frozen, o_left/o_right hold a snapshot and the internal count continues.
  - A second lap edge returns the outputs to the live count.
  - Clear drops the freeze flag. A lap edge in IDLE is ignored.
  - o_tick and o_wrap always reflect the internal count.
- Undefined: the i_lap port is absent and the outputs always show the live count.

Decomposition:
- Shared package go_board_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2;
  - DIGIT_W=4;
  - the default 25 MHz CLKS_PER_TICK constant.
- One natural sub-module: rise_edge_detect (async active-low reset, history reset to 1), instantiated for start, clear and lap.

Test Plan:
All scenarios use CLKS_PER_TICK=4 and DIGIT_MAX=9 unless stated.
1. Reset release with i_start_stop held high -> o_running stays 0 and digits stay 00 for 20 cycles; no edge is detected.
2. Start edge, count up for 12 ticks -> o_tick every 4 cycles, digits 01..09 then 10, 11, 12; o_wrap stays 0.
3. Preload 98 by running, then 2 ticks up -> 99 then 00 with o_wrap high for exactly 1 cycle; set i_count_down=1 and take 1 tick -> 99 with an o_wrap pulse.
4. Start edge 2 cycles into a tick period (pause), wait 50 cycles, start edge again -> digits unchanged during PAUSED; next o_tick 2 cycles after resume.
5. Clear and start edges in the same cycle while in RUN at 37 -> next cycle shows 00, o_running=0, state IDLE.
6. DIGIT_MAX=15, 17 ticks up -> digits 0x11. With DIGIT_COUNTER_LAP_EN, lap at 0x05 then 3 ticks -> outputs hold 05; a second lap edge shows 08.

Source files
------------

// File: rtl/digit_counter_2d_pkg.sv
// Shared Go Board definitions: counter FSM state encodings, digit width and default prescale.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package go_board_pkg;

    localparam int DIGIT_W             = 4;
    localparam int CLKS_PER_TICK_25MHZ = 25000000;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

endpackage

// File: rtl/digit_counter_2d_if.sv
// Switch-side inputs and display-side outputs of the two-digit counter.
// Latency: n/a (wires only).
// Backpressure: none; levels and pulses, no handshake.
// i_lap exists only when DIGIT_COUNTER_LAP_EN is defined.
interface digit_counter_2d_if;
    import go_board_pkg::*;

    logic   i_start_stop;
    logic   i_clear;
    logic   i_count_down;
`ifdef DIGIT_COUNTER_LAP_EN
    logic   i_lap;
`endif
    digit_t o_left_digit;
    digit_t o_right_digit;
    logic   o_running;
    logic   o_tick;
    logic   o_wrap;

    // Drives the switches, observes the display.
    modport master (
        output i_start_stop, i_clear, i_count_down,
`ifdef DIGIT_COUNTER_LAP_EN
        output i_lap,
`endif
        input  o_left_digit, o_right_digit, o_running, o_tick, o_wrap
    );

    // The counter itself.
    modport slave (
        input  i_start_stop, i_clear, i_count_down,
`ifdef DIGIT_COUNTER_LAP_EN
        input  i_lap,
`endif
        output o_left_digit, o_right_digit, o_running, o_tick, o_wrap
    );

endinterface

// File: rtl/digit_counter_2d_rise_edge_detect.sv
// Rising-edge detector for an already-debounced switch level.
// Latency: o_rise is combinational off the current level; history is one register.
// Backpressure: none.
module rise_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic prev_q;

    // History resets high so a switch already held at reset release is not seen as an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) prev_q <= 1'b1;
        else          prev_q <= i_level;
    end

    assign o_rise = i_level & ~prev_q;

endmodule

// File: rtl/digit_counter_2d.sv
// Two-digit run/pause/clear up/down counter feeding the pair of 7-segment decoders.
// Latency: switch edge acts on the sampling clock, new state visible next cycle; digits/o_tick registered.
// Backpressure: none; DIGIT_COUNTER_LAP_EN adds i_lap to freeze the displayed digits.
module digit_counter_2d
    import go_board_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_25MHZ,
    parameter int DIGIT_MAX     = 9
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    digit_counter_2d_if.slave bus
);

    localparam int               PRESC_W    = $clog2(CLKS_PER_TICK);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);
    localparam digit_t           DMAX       = digit_t'(DIGIT_MAX);

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q;
    digit_t              left_q, right_q;
    digit_t              step_left, step_right;
    logic                step_wrap;
    logic                tick_q, wrap_q;
    logic                start_rise, clear_rise;

    rise_edge_detect u_start_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (bus.i_start_stop),
        .o_rise  (start_rise)
    );

    rise_edge_detect u_clear_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (bus.i_clear),
        .o_rise  (clear_rise)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: clear beats a simultaneous start edge; start toggles run/pause.
    always_comb begin
        state_d = state_q;
        if (clear_rise) begin
            state_d = ST_IDLE;
        end else if (start_rise) begin
            case (state_q)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN:    state_d = ST_PAUSED;
                ST_PAUSED: state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // One count step in the sampled direction, with rollover in both directions.
    always_comb begin
        step_left  = left_q;
        step_right = right_q;
        step_wrap  = 1'b0;
        if (bus.i_count_down) begin
            if (right_q == '0) begin
                step_right = DMAX;
                if (left_q == '0) begin
                    step_left = DMAX;
                    step_wrap = 1'b1;
                end else begin
                    step_left = left_q - 1'b1;
                end
            end else begin
                step_right = right_q - 1'b1;
            end
        end else begin
            if (right_q == DMAX) begin
                step_right = '0;
                if (left_q == DMAX) begin
                    step_left = '0;
                    step_wrap = 1'b1;
                end else begin
                    step_left = left_q + 1'b1;
                end
            end else begin
                step_right = right_q + 1'b1;
            end
        end
    end

    // Prescaler runs only in RUN (holds when paused); its last count steps the digits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (clear_rise) begin
                presc_q <= '0;
                left_q  <= '0;
                right_q <= '0;
            end else if (state_q == ST_RUN) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    left_q  <= step_left;
                    right_q <= step_right;
                    tick_q  <= 1'b1;
                    wrap_q  <= step_wrap;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign bus.o_running = (state_q == ST_RUN);
    assign bus.o_tick    = tick_q;
    assign bus.o_wrap    = wrap_q;

`ifdef DIGIT_COUNTER_LAP_EN
    logic   lap_rise;
    logic   frozen_q;
    digit_t snap_left_q, snap_right_q;

    rise_edge_detect u_lap_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (bus.i_lap),
        .o_rise  (lap_rise)
    );

    // Lap edges outside IDLE toggle a display freeze; the snapshot is the value on show at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frozen_q     <= 1'b0;
            snap_left_q  <= '0;
            snap_right_q <= '0;
        end else if (clear_rise) begin
            frozen_q <= 1'b0;
        end else if (lap_rise && (state_q != ST_IDLE)) begin
            frozen_q     <= ~frozen_q;
            snap_left_q  <= left_q;
            snap_right_q <= right_q;
        end
    end

    assign bus.o_left_digit  = frozen_q ? snap_left_q  : left_q;
    assign bus.o_right_digit = frozen_q ? snap_right_q : right_q;
`else
    assign bus.o_left_digit  = left_q;
    assign bus.o_right_digit = right_q;
`endif

endmodule
